// File: rtl/inst_mem_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_pkg
// Shared definitions for the instruction block memory:
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - block, word, lane and address width constants
//   - default read latency and latency-counter width
//   - helpers that split a program-load word address into block and lane
// ---------------------------------------------------------------------------
package inst_mem_pkg;

    localparam int WORD_W          = 32;
    localparam int NUM_LANES       = 4;
    localparam int BLOCK_W         = WORD_W * NUM_LANES;
    localparam int BLOCK_AW        = 6;
    localparam int NUM_BLOCKS      = 1 << BLOCK_AW;
    localparam int LANE_AW         = 2;
    localparam int LOAD_AW         = BLOCK_AW + LANE_AW;
    localparam int DEFAULT_LATENCY = 5;
    // Holds LATENCY-1, so 4 bits covers the full 1..16 latency range.
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [BLOCK_AW-1:0] load_block(input logic [LOAD_AW-1:0] addr);
        return addr[LOAD_AW-1:LANE_AW];
    endfunction

    function automatic logic [LANE_AW-1:0] load_lane(input logic [LOAD_AW-1:0] addr);
        return addr[LANE_AW-1:0];
    endfunction

endpackage

// File: rtl/inst_block_memory_if.sv
// ---------------------------------------------------------------------------
// inst_block_memory_if
// Bus between the instruction cache / program loader and the block memory.
//   READ      cache -> mem   block read request, held until BUSYWAIT falls
//   ADDRESS   cache -> mem   6-bit block address
//   READDATA  mem -> cache   128-bit fetched block, lane k = bits [32k+31:32k]
//   BUSYWAIT  mem -> cache   high while a read is outstanding
//   LOAD_EN   loader -> mem  program-image write strobe
//   LOAD_ADDR loader -> mem  word address ([7:2] block, [1:0] lane)
//   LOAD_DATA loader -> mem  instruction word to write
// master = cache/loader side, slave = memory side.
// ---------------------------------------------------------------------------
interface inst_block_memory_if;
    import inst_mem_pkg::*;

    logic                READ;
    logic [BLOCK_AW-1:0] ADDRESS;
    logic [BLOCK_W-1:0]  READDATA;
    logic                BUSYWAIT;
    logic                LOAD_EN;
    logic [LOAD_AW-1:0]  LOAD_ADDR;
    logic [WORD_W-1:0]   LOAD_DATA;

    modport master (
        output READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        output READDATA, BUSYWAIT
    );

endinterface

// File: rtl/inst_mem_array.sv
// ---------------------------------------------------------------------------
// inst_mem_array
// 64 x 128-bit instruction storage, organised as four 32-bit lane memories so
// a single program word can be written without touching its neighbours.
// Contents are never cleared.
//   i_clk       clock
//   i_wr_en     word write strobe
//   i_wr_block  block being written
//   i_wr_lane   lane within the block being written
//   i_wr_data   word to write
//   i_rd_block  block to read
//   o_rd_data   block contents (combinational read; the caller registers it)
// The read is asynchronous so the caller's output register captures the
// contents as they stand just before its capture edge: a write on that same
// edge is not seen, a write on any earlier edge is.
// ---------------------------------------------------------------------------
module inst_mem_array
    import inst_mem_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [BLOCK_AW-1:0] i_wr_block,
    input  logic [LANE_AW-1:0]  i_wr_lane,
    input  logic [WORD_W-1:0]   i_wr_data,
    input  logic [BLOCK_AW-1:0] i_rd_block,
    output logic [BLOCK_W-1:0]  o_rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [WORD_W-1:0] r_lane_mem [0:NUM_BLOCKS-1];
            logic              w_lane_we;

            assign w_lane_we = i_wr_en && (i_wr_lane == LANE_AW'(gi));

            always_ff @(posedge i_clk) begin
                if (w_lane_we) begin
                    r_lane_mem[i_wr_block] <= i_wr_data;
                end
            end

            assign o_rd_data[gi*WORD_W +: WORD_W] = r_lane_mem[i_rd_block];
        end
    endgenerate

endmodule

// File: rtl/inst_block_memory.sv
// ---------------------------------------------------------------------------
// inst_block_memory
// Multi-cycle instruction block memory serving an instruction cache, with a
// word-wide program-load port usable at any time.
//   CLOCK    clock, all state changes on its rising edge
//   RESET    asynchronous active-low reset (storage is not cleared)
//   bus      inst_block_memory_if.slave (READ/ADDRESS/READDATA/BUSYWAIT and
//            LOAD_EN/LOAD_ADDR/LOAD_DATA)
// Parameter LATENCY (1..16): edges from the edge that accepts READ in IDLE to
// the edge that drops BUSYWAIT and updates READDATA.
// ---------------------------------------------------------------------------
module inst_block_memory
    import inst_mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
)(
    input  logic          CLOCK,
    input  logic          RESET,
    inst_block_memory_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic [BLOCK_AW-1:0] r_addr;
    logic [BLOCK_AW-1:0] w_addr_next;
    logic [BLOCK_W-1:0]  r_readdata;
    logic [BLOCK_W-1:0]  w_readdata_next;
    logic                w_busywait;
    logic [BLOCK_W-1:0]  w_mem_rd;

    inst_mem_array u_array (
        .i_clk      (CLOCK),
        .i_wr_en    (bus.LOAD_EN),
        .i_wr_block (load_block(bus.LOAD_ADDR)),
        .i_wr_lane  (load_lane(bus.LOAD_ADDR)),
        .i_wr_data  (bus.LOAD_DATA),
        .i_rd_block (r_addr),
        .o_rd_data  (w_mem_rd)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_addr     <= '0;
            r_readdata <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_addr     <= w_addr_next;
            r_readdata <= w_readdata_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_addr_next     = r_addr;
        w_readdata_next = r_readdata;
        w_busywait      = 1'b0;

        case (r_state)
            IDLE: begin
                // Request is reflected immediately so the cache stalls in the
                // same cycle it asks, including back-to-back misses.
                w_busywait = bus.READ;
                if (bus.READ) begin
                    w_addr_next  = bus.ADDRESS;
                    w_count_next = CNT_LOAD;
                    w_state_next = BUSY;
                end
            end

            BUSY: begin
                w_busywait = 1'b1;
                // A withdrawn request abandons the read and keeps the last
                // completed block on READDATA.
                if (!bus.READ) begin
                    w_state_next = IDLE;
                end else if (r_count == '0) begin
                    w_readdata_next = w_mem_rd;
                    w_state_next    = DONE;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.READDATA = r_readdata;
    assign bus.BUSYWAIT = w_busywait;

endmodule

// File: tb/tb_inst_block_memory.sv
// ---------------------------------------------------------------------------
// tb_inst_block_memory
// Directed bench for inst_block_memory: one instance at the default latency
// and one at latency 1. Expected blocks come from a word-level model of the
// program image and are queued when a read is issued, then popped and
// compared when BUSYWAIT falls.
// ---------------------------------------------------------------------------
module tb_inst_block_memory;
    import inst_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_block_memory_if if5();
    inst_block_memory_if if1();

    inst_block_memory #(.LATENCY(5)) dut5 (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (if5.slave)
    );

    inst_block_memory #(.LATENCY(1)) dut1 (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (if1.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] sb_q [$];
    logic [31:0]  mdl [0:63][0:3];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [127:0] obs);
        logic [127:0] exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            assert (sb_q.size() != 0) else begin
                n_errors++;
                $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
            end
        end else begin
            exp = sb_q.pop_front();
            chk(tag, obs, exp);
            $display("read  %-10s data=%h", tag, obs);
        end
    endtask

    function automatic logic [127:0] blk(input int b);
        return {mdl[b][3], mdl[b][2], mdl[b][1], mdl[b][0]};
    endfunction

    // Called at a falling edge; writes one word on the next rising edge.
    task automatic load(input logic [7:0] a, input logic [31:0] d);
        if5.LOAD_EN = 1'b1; if5.LOAD_ADDR = a; if5.LOAD_DATA = d;
        if1.LOAD_EN = 1'b1; if1.LOAD_ADDR = a; if1.LOAD_DATA = d;
        @(negedge clk);
        if5.LOAD_EN = 1'b0;
        if1.LOAD_EN = 1'b0;
        mdl[a[7:2]][a[1:0]] = d;
        $display("load  addr=%h data=%h", a, d);
    endtask

    // Counts falling edges until BUSYWAIT is seen low (bounded).
    task automatic wait_fall(input int sel, output int n);
        logic bw;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bw = (sel == 5) ? if5.BUSYWAIT : if1.BUSYWAIT;
        end while (bw && n < 40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        if5.READ = 1'b0; if5.ADDRESS = '0; if5.LOAD_EN = 1'b0; if5.LOAD_ADDR = '0; if5.LOAD_DATA = '0;
        if1.READ = 1'b0; if1.ADDRESS = '0; if1.LOAD_EN = 1'b0; if1.LOAD_ADDR = '0; if1.LOAD_DATA = '0;
        @(negedge clk);

        // Reset state
        chk("rst_rd5", if5.READDATA, 128'h0);
        chk("rst_bw5", 128'(if5.BUSYWAIT), 128'h0);
        chk("rst_rd1", if1.READDATA, 128'h0);
        chk("rst_bw1", 128'(if1.BUSYWAIT), 128'h0);
        rst_n = 1'b1;

        // Program image: blocks 5, 9 and 0
        for (int k = 0; k < 4; k++) begin
            load(8'h14 + 8'(k), 32'hAAAA0000 + 32'(k));
            load(8'h24 + 8'(k), 32'h99990000 + 32'(k));
            load(8'h00 + 8'(k), 32'hC0DE0000 + 32'(k));
        end

        // Basic read of block 5 at latency 5
        if5.ADDRESS = 6'd5; if5.READ = 1'b1;
        #1 chk("A_bw_comb", 128'(if5.BUSYWAIT), 128'h1);
        sb_q.push_back(blk(5));
        wait_fall(5, n);
        chk("A_latency", 128'(n), 128'(6));
        chk("A_literal", if5.READDATA, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
        pop_check("A_data", if5.READDATA);

        // Back-to-back: READ stays high through DONE, new address 9
        if5.ADDRESS = 6'd9;
        sb_q.push_back(blk(9));
        @(negedge clk);
        chk("B_bw_idle", 128'(if5.BUSYWAIT), 128'h1);
        chk("B_hold", if5.READDATA, blk(5));
        wait_fall(5, n);
        chk("B_latency", 128'(n), 128'(6));
        pop_check("B_data", if5.READDATA);
        if5.READ = 1'b0;
        @(negedge clk);

        // Address change during BUSY is ignored
        if5.ADDRESS = 6'd5; if5.READ = 1'b1;
        sb_q.push_back(blk(5));
        @(negedge clk);
        if5.ADDRESS = 6'd9;
        wait_fall(5, n);
        chk("C_latency", 128'(n), 128'(5));
        pop_check("C_data", if5.READDATA);
        if5.READ = 1'b0;
        @(negedge clk);

        // Abort: READ dropped in the 3rd BUSY cycle
        if5.ADDRESS = 6'd9; if5.READ = 1'b1;
        repeat (3) @(negedge clk);
        if5.READ = 1'b0;
        #1 chk("D_bw_busy", 128'(if5.BUSYWAIT), 128'h1);
        @(negedge clk);
        chk("D_bw", 128'(if5.BUSYWAIT), 128'h0);
        chk("D_state", 128'(dut5.r_state), 128'(IDLE));
        chk("D_rd", if5.READDATA, blk(5));
        repeat (6) @(negedge clk);
        chk("D_rd_late", if5.READDATA, blk(5));
        $display("abort addr=9 readdata kept");

        // Reset mid-BUSY with READ held high
        if5.ADDRESS = 6'd9; if5.READ = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("E_rd_now", if5.READDATA, 128'h0);
        chk("E_state", 128'(dut5.r_state), 128'(IDLE));
        chk("E_bw_read", 128'(if5.BUSYWAIT), 128'(if5.READ));
        @(negedge clk);
        chk("E_rd_held", if5.READDATA, 128'h0);
        rst_n = 1'b1;
        sb_q.push_back(blk(9));
        wait_fall(5, n);
        chk("E_latency", 128'(n), 128'(6));
        pop_check("E_data", if5.READDATA);
        if5.READ = 1'b0;
        @(negedge clk);

        // Load on the completion edge returns the old lane 2
        if5.ADDRESS = 6'd5; if5.READ = 1'b1;
        sb_q.push_back(blk(5));
        repeat (5) @(negedge clk);
        chk("F_bw_pre", 128'(if5.BUSYWAIT), 128'h1);
        if5.LOAD_EN = 1'b1; if5.LOAD_ADDR = 8'h16; if5.LOAD_DATA = 32'hBEEF0002;
        @(negedge clk);
        if5.LOAD_EN = 1'b0;
        mdl[5][2] = 32'hBEEF0002;
        chk("F_bw", 128'(if5.BUSYWAIT), 128'h0);
        pop_check("F_old", if5.READDATA);
        if5.READ = 1'b0;
        @(negedge clk);

        // Next read sees new lane 2, plus a lane-3 load made mid-read
        if5.ADDRESS = 6'd5; if5.READ = 1'b1;
        mdl[5][3] = 32'h5A5A0003;
        sb_q.push_back(blk(5));
        repeat (2) @(negedge clk);
        if5.LOAD_EN = 1'b1; if5.LOAD_ADDR = 8'h17; if5.LOAD_DATA = 32'h5A5A0003;
        @(negedge clk);
        if5.LOAD_EN = 1'b0;
        wait_fall(5, n);
        chk("F2_latency", 128'(n), 128'(3));
        pop_check("F2_new", if5.READDATA);
        if5.READ = 1'b0;
        @(negedge clk);

        // Latency 1 instance, block 0
        if1.ADDRESS = 6'd0; if1.READ = 1'b1;
        #1 chk("G_bw_comb", 128'(if1.BUSYWAIT), 128'h1);
        sb_q.push_back(blk(0));
        wait_fall(1, n);
        chk("G_latency", 128'(n), 128'(2));
        pop_check("G_data", if1.READDATA);
        if1.READ = 1'b0;
        repeat (2) @(negedge clk);
        chk("G_hold", if1.READDATA, blk(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
